com_seq_emitter: RTL and testbench
==================================

# com_seq_emitter

Parametrised bytecode-to-ARM sequence emitter for the JIT translation path. It takes one JVM bytecode opcode per handshake and streams its multi-word ARM template, one 32-bit instruction per beat, to the code buffer. Flow control is valid/ready on both sides. It extends the single-word combinational translation ROM with per-opcode sequence lengths, back-pressure and an error flag, and can optionally be reloaded at run time.

## Interface
- OP_W, 3, opcode width; the table holds 2^OP_W opcodes.
- INSTR_W, 32, emitted instruction width.
- MAX_SEQ, 4, maximum words per opcode template (≥1).
- LEN_W, $clog2(MAX_SEQ+1), width of the length field.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  opcode offered.
- in_ready  out  1  emitter can accept an opcode.
- in_op  in  OP_W  bytecode opcode.
- out_valid  out  1  out_data holds a valid instruction.
- out_ready  in  1  consumer takes the word.
- out_data  out  INSTR_W  ARM instruction word.
- out_last  out  1  final word of the current sequence.
- out_err  out  1  current word belongs to an undefined opcode.
- busy  out  1  a sequence is in flight.
- wr_en, wr_op[OP_W], wr_idx[$clog2(MAX_SEQ)], wr_data[INSTR_W], wr_len_en, wr_len[LEN_W]  in  table write port. Present only with COM_ROM_WRITE_EN.

## Operation
- Table: the word array is indexed {op, idx}. A length array holds one entry per opcode.
- Default contents:
  - op 0 (IADD), len 3: E83D0003, E0800001, E9AD0001.
  - op 1 (ISUB), len 3: E83D0003, E0400001, E9AD0001.
  - op 2 (NOP), len 1: E1A00000.
  - All other opcodes: len 0.
- An opcode is undefined when its length is 0 or greater than MAX_SEQ. An undefined opcode emits exactly one word, all ones, with out_last=1 and out_err=1.
- State machine states: IDLE and EMIT.
  - IDLE: in_ready=1. On in_valid: latch in_op, load word 0 into out_data, set out_valid=1, set idx=0, go to EMIT.
  - EMIT: in_ready=0. On out_valid&&out_ready:
    - If out_last: clear out_valid and return to IDLE.
    - Otherwise: idx+1, load the next word, and set out_last when idx+1 == len-1.
- out_data, out_last and out_err hold stable while out_valid=1 and out_ready=0.
- busy = (state == EMIT).
- idx never wraps. Words beyond len are never emitted.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_err=0, busy=0, in_ready=1, state=IDLE, idx=0, table=default contents.
- Reset asserted mid-sequence aborts it immediately. No partial words follow.
- Latency: the first word is valid 1 cycle after the input handshake.
- With out_ready held high, a len-N sequence occupies N consecutive beats.
- After the last beat there is one idle cycle before the next accept: in_ready rises the cycle after the last handshake. Throughput is N+1 cycles per opcode.
- out_last is combinationally consistent with out_data in the same cycle.
- len=1: the first word is loaded with out_last=1.

## Configuration
- COM_ROM_WRITE_EN:
  - Defined:
    - Write port present.
    - wr_en writes wr_data to word {wr_op, wr_idx} at the clock edge.
    - wr_len_en writes wr_len to the length entry of wr_op.
    - Writes are accepted at any time. A word is read when it is loaded into out_data, so a write to a later word of the in-flight opcode takes effect for that sequence.
    - Simultaneous wr_en and wr_len_en are both performed.
  - Undefined:
    - No write port.
    - The table is constant default contents, implemented as case logic.

## Test plan
- Reset, then in_op=0 with out_ready=1 -> out_data E83D0003, E0800001, E9AD0001 on 3 consecutive beats starting 1 cycle after accept; out_last only on the 3rd beat; then in_ready=1.
- in_op=1 with out_ready low for 3 cycles on beat 2 -> E0400001 held stable with out_valid=1; sequence completes; out_err=0 throughout.
- in_op=2 -> a single beat E1A00000 with out_last=1. in_op=5 -> a single beat FFFFFFFF with out_last=1 and out_err=1.
- in_valid held high during an IADD sequence -> in_ready=0 until the cycle after the last handshake; the second opcode is accepted then.
- rst_n pulsed low during beat 2 of IADD -> out_valid=0 and busy=0 at once; a new accept after release restarts from E83D0003.
- With COM_ROM_WRITE_EN: write op 7 len 2, words 11111111 and 22222222 -> in_op=7 emits them with out_err=0. Writing len 0 to op 2 -> in_op=2 produces the error beat.

Source files
------------

// File: rtl/com_seq_emitter.sv
// com_seq_emitter
// Translates one JVM bytecode opcode per input handshake into its ARM
// instruction template. The template is streamed to the code buffer one
// 32-bit word per output beat. An opcode with no template, or with a length
// larger than MAX_SEQ, produces a single all-ones word flagged with out_err.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     opcode handshake, opcode on in_op
//   out_valid/out_ready   instruction handshake, word on out_data
//   out_last              final word of the current sequence
//   out_err               word belongs to an undefined opcode
//   busy                  a sequence is in flight
//   wr_*                  table write port (only with COM_ROM_WRITE_EN)
//
// Build option: define COM_ROM_WRITE_EN to make the table writable at run
// time. Without it, the table is fixed case logic.
module com_seq_emitter #(
  parameter int OP_W    = 3,
  parameter int INSTR_W = 32,
  parameter int MAX_SEQ = 4,
  parameter int LEN_W   = $clog2(MAX_SEQ + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_data,
  output logic               out_last,
  output logic               out_err,
  output logic               busy
`ifdef COM_ROM_WRITE_EN
  ,
  input  logic               wr_en,
  input  logic [OP_W-1:0]    wr_op,
  input  logic [((MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1)-1:0] wr_idx,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               wr_len_en,
  input  logic [LEN_W-1:0]   wr_len
`endif
);

  localparam int IDX_W = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
  localparam int N_OPS = 1 << OP_W;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // Built-in templates: IADD, ISUB, NOP.
  function automatic logic [INSTR_W-1:0] def_word(input logic [OP_W-1:0] op,
                                                  input logic [IDX_W-1:0] idx);
    logic [INSTR_W-1:0] w;
    w = '0;
    if (op == OP_W'(0) || op == OP_W'(1)) begin
      case (idx)
        IDX_W'(0): w = INSTR_W'(32'hE83D0003);
        IDX_W'(1): w = (op == OP_W'(0)) ? INSTR_W'(32'hE0800001)
                                        : INSTR_W'(32'hE0400001);
        IDX_W'(2): w = INSTR_W'(32'hE9AD0001);
        default:   w = '0;
      endcase
    end else if (op == OP_W'(2) && idx == '0) begin
      w = INSTR_W'(32'hE1A00000);
    end
    return w;
  endfunction

  function automatic logic [LEN_W-1:0] def_len(input logic [OP_W-1:0] op);
    logic [LEN_W-1:0] l;
    case (op)
      OP_W'(0), OP_W'(1): l = LEN_W'(3);
      OP_W'(2):           l = LEN_W'(1);
      default:            l = '0;
    endcase
    return l;
  endfunction

  state_t               r_state;
  state_t               w_state_next;
  logic [OP_W-1:0]      r_op;
  logic [IDX_W-1:0]     r_idx;
  logic [LEN_W-1:0]     r_len;
  logic                 r_out_valid;
  logic [INSTR_W-1:0]   r_out_data;
  logic                 r_out_last;
  logic                 r_out_err;

  logic [OP_W-1:0]      w_rd_op;
  logic [IDX_W-1:0]     w_rd_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [INSTR_W-1:0]   w_rd_word;
  logic [LEN_W-1:0]     w_len_in;
  logic                 w_in_undef;
  logic                 w_next_last;
  logic                 w_accept;
  logic                 w_fire;

  // One table read port: word 0 of the offered opcode while idle, the
  // following word of the latched opcode while emitting.
  assign w_idx_nxt = r_idx + IDX_W'(1);
  assign w_rd_op   = (r_state == S_IDLE) ? in_op : r_op;
  assign w_rd_idx  = (r_state == S_IDLE) ? '0 : w_idx_nxt;

`ifdef COM_ROM_WRITE_EN
  logic [INSTR_W-1:0] r_mem     [N_OPS * (1 << IDX_W)];
  logic [LEN_W-1:0]   r_len_tab [N_OPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OPS * (1 << IDX_W); i++) begin
        r_mem[i] <= def_word(i[OP_W+IDX_W-1:IDX_W], i[IDX_W-1:0]);
      end
      for (int i = 0; i < N_OPS; i++) begin
        r_len_tab[i] <= def_len(i[OP_W-1:0]);
      end
    end else begin
      if (wr_en) begin
        r_mem[{wr_op, wr_idx}] <= wr_data;
      end
      if (wr_len_en) begin
        r_len_tab[wr_op] <= wr_len;
      end
    end
  end

  assign w_rd_word = r_mem[{w_rd_op, w_rd_idx}];
  assign w_len_in  = r_len_tab[in_op];
`else
  assign w_rd_word = def_word(w_rd_op, w_rd_idx);
  assign w_len_in  = def_len(in_op);
`endif

  assign w_in_undef  = (w_len_in == '0) || (w_len_in > LEN_W'(MAX_SEQ));
  // Length is latched at accept, so the last-word test uses the length the
  // sequence started with.
  assign w_next_last = (LEN_W'(w_idx_nxt) == (r_len - LEN_W'(1)));
  assign w_accept    = in_ready && in_valid;
  assign w_fire      = r_out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_EMIT;
      S_EMIT:  if (w_fire && r_out_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (r_state == S_IDLE);
    busy     = (r_state == S_EMIT);
  end

  // Output word register and sequence position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_op        <= in_op;
      r_idx       <= '0;
      r_len       <= w_len_in;
      r_out_valid <= 1'b1;
      if (w_in_undef) begin
        r_out_data <= '1;
        r_out_last <= 1'b1;
        r_out_err  <= 1'b1;
      end else begin
        r_out_data <= w_rd_word;
        r_out_last <= (w_len_in == LEN_W'(1));
        r_out_err  <= 1'b0;
      end
    end else if (r_state == S_EMIT && w_fire) begin
      if (r_out_last) begin
        r_out_valid <= 1'b0;
      end else begin
        r_idx      <= w_idx_nxt;
        r_out_data <= w_rd_word;
        r_out_last <= w_next_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_com_seq_emitter.sv
module tb_com_seq_emitter;

  localparam int OP_W    = 3;
  localparam int INSTR_W = 32;
  localparam int MAX_SEQ = 4;
  localparam int LEN_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [OP_W-1:0]    in_op = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] out_data;
  logic               out_last;
  logic               out_err;
  logic               busy;
`ifdef COM_ROM_WRITE_EN
  logic               wr_en = 1'b0;
  logic [OP_W-1:0]    wr_op = '0;
  logic [1:0]         wr_idx = '0;
  logic [INSTR_W-1:0] wr_data = '0;
  logic               wr_len_en = 1'b0;
  logic [LEN_W-1:0]   wr_len = '0;
`endif

  com_seq_emitter #(
    .OP_W(OP_W), .INSTR_W(INSTR_W), .MAX_SEQ(MAX_SEQ), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .busy(busy)
`ifdef COM_ROM_WRITE_EN
    , .wr_en(wr_en), .wr_op(wr_op), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_len_en(wr_len_en), .wr_len(wr_len)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic        err;
  } beat_t;

  // Reference model: table contents plus a queue of words still owed.
  logic [31:0] m_word [8][4];
  int          m_len  [8];
  beat_t       exp_q [$];
  beat_t       obs_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_nbeats(input int op);
    if (m_len[op] == 0 || m_len[op] > MAX_SEQ) return 1;
    return m_len[op];
  endfunction

  function automatic beat_t model_beat(input int op, input int i);
    beat_t b;
    if (m_len[op] == 0 || m_len[op] > MAX_SEQ) begin
      b.d = 32'hFFFFFFFF; b.last = 1'b1; b.err = 1'b1;
    end else begin
      b.d = m_word[op][i]; b.last = (i == m_len[op] - 1); b.err = 1'b0;
    end
    return b;
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_err", out_err, 0);
    end else begin
      check("in_ready", in_ready, exp_q.size() == 0);
      check("busy", busy, exp_q.size() != 0);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_data", out_data, e.d);
        check("out_last", out_last, e.last);
        check("out_err", out_err, e.err);
        if (out_ready) begin
          obs_q.push_back({out_data, out_last, out_err});
          void'(exp_q.pop_front());
        end
      end else if (in_valid) begin
        for (int i = 0; i < model_nbeats(in_op); i++) exp_q.push_back(model_beat(in_op, i));
      end
`ifdef COM_ROM_WRITE_EN
      if (wr_en) m_word[wr_op][wr_idx] = wr_data;
      if (wr_len_en) m_len[wr_op] = int'(wr_len);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick(1);
      k++;
    end
    check("idle_timeout", k < 100, 1);
  endtask

  task automatic run_op(input int op);
    obs_q.delete();
    in_op = 3'(op);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    beat_t b;
    for (int o = 0; o < 8; o++) begin
      m_len[o] = 0;
      for (int i = 0; i < 4; i++) m_word[o][i] = 32'h0;
    end
    m_len[0] = 3; m_len[1] = 3; m_len[2] = 1;
    m_word[0][0] = 32'hE83D0003; m_word[0][1] = 32'hE0800001; m_word[0][2] = 32'hE9AD0001;
    m_word[1][0] = 32'hE83D0003; m_word[1][1] = 32'hE0400001; m_word[1][2] = 32'hE9AD0001;
    m_word[2][0] = 32'hE1A00000;

    // Pin the model itself.
    check("model_len_iadd", model_nbeats(0), 3);
    b = model_beat(0, 1);
    check("model_iadd_w1", b.d, 32'hE0800001);
    check("model_undef_n", model_nbeats(5), 1);
    b = model_beat(5, 0);
    check("model_undef_beat", {b.last, b.err}, 2'b11);

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // IADD streamed back-to-back, first word one cycle after accept.
    obs_q.delete();
    in_op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("iadd_latency_valid", out_valid, 1);
    wait_idle();
    check("iadd_nbeats", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("iadd_w0", obs_q[0].d, 32'hE83D0003);
      check("iadd_w1", obs_q[1].d, 32'hE0800001);
      check("iadd_w2", obs_q[2].d, 32'hE9AD0001);
      check("iadd_last", {obs_q[0].last, obs_q[1].last, obs_q[2].last}, 3'b001);
    end
    check("iadd_in_ready_after", in_ready, 1);

    // ISUB with back-pressure on beat 2.
    obs_q.delete();
    in_op = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("isub_hold_data", out_data, 32'hE0400001);
      check("isub_hold_valid", out_valid, 1);
      tick(1);
    end
    out_ready = 1'b1;
    wait_idle();
    check("isub_nbeats", obs_q.size(), 3);
    for (int i = 0; i < obs_q.size(); i++) check("isub_err", obs_q[i].err, 0);

    // NOP and an undefined opcode.
    run_op(2);
    check("nop_nbeats", obs_q.size(), 1);
    if (obs_q.size() == 1) check("nop_beat", {obs_q[0].d, obs_q[0].last, obs_q[0].err}, {32'hE1A00000, 2'b10});
    run_op(5);
    check("undef_nbeats", obs_q.size(), 1);
    if (obs_q.size() == 1) check("undef_beat", {obs_q[0].d, obs_q[0].last, obs_q[0].err}, {32'hFFFFFFFF, 2'b11});

    // in_valid held through an IADD: next opcode accepted after the idle cycle.
    in_op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick(1);
    in_op = 3'd2;
    for (int k = 0; k < 3; k++) begin
      check("hold_in_ready_low", in_ready, 0);
      tick(1);
    end
    check("hold_in_ready_high", in_ready, 1);
    tick(1);
    in_valid = 1'b0;
    check("hold_second_data", out_data, 32'hE1A00000);
    check("hold_second_last", out_last, 1);
    wait_idle();

    // Reset in the middle of an IADD.
    in_op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    check("mid_beat2", out_data, 32'hE0800001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    obs_q.delete();
    in_op = 3'd0; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    check("restart_w0", out_data, 32'hE83D0003);
    wait_idle();
    check("restart_nbeats", obs_q.size(), 3);

`ifdef COM_ROM_WRITE_EN
    // Reload op 7 with two words, then undefine NOP.
    wr_en = 1'b1; wr_op = 3'd7; wr_idx = 2'd0; wr_data = 32'h11111111;
    wr_len_en = 1'b1; wr_len = 3'd2;
    tick(1);
    wr_idx = 2'd1; wr_data = 32'h22222222; wr_len_en = 1'b0;
    tick(1);
    wr_en = 1'b0;
    run_op(7);
    check("wr_op7_nbeats", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("wr_op7_beat0", {obs_q[0].d, obs_q[0].last, obs_q[0].err}, {32'h11111111, 2'b00});
      check("wr_op7_beat1", {obs_q[1].d, obs_q[1].last, obs_q[1].err}, {32'h22222222, 2'b10});
    end
    wr_len_en = 1'b1; wr_op = 3'd2; wr_len = 3'd0;
    tick(1);
    wr_len_en = 1'b0;
    run_op(2);
    check("wr_nop_undef", obs_q.size(), 1);
    if (obs_q.size() == 1) check("wr_nop_beat", {obs_q[0].d, obs_q[0].last, obs_q[0].err}, {32'hFFFFFFFF, 2'b11});
`endif

    // Randomised traffic with random back-pressure.
    for (int c = 0; c < 2500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_op     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      tick(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
